// File: rtl/param_sync_fifo_pkg.sv
// Shared defaults and read-mode encoding for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 16;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// FIFO push/pop bus: the producer/consumer side is master, the FIFO is slave.
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] data_i;
  logic             pop;
  logic [WIDTH-1:0] data_o;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, data_i, pop,
    input  data_o, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, data_i, pop,
    output data_o, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/param_sync_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with occupancy flags, overflow/underflow pulses and
// selectable registered or first-word-fall-through read data.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_DEF_WIDTH,
  parameter int DEPTH     = FIFO_DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  param_sync_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam bit IS_FWFT = (FWFT == int'(FIFO_MODE_FWFT));

  if (WIDTH < 1 || !is_pow2(DEPTH)) begin : g_bad_geometry
    $error("param_sync_fifo: WIDTH must be >=1 and DEPTH a power of two >=2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
    $error("param_sync_fifo: AF_THRESH or AE_THRESH out of range");
  end
  if (FWFT != int'(FIFO_MODE_STD) && FWFT != int'(FIFO_MODE_FWFT)) begin : g_bad_mode
    $error("param_sync_fifo: FWFT must be 0 or 1");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full_s, empty_s, wr_en_s, rd_en_s;
  logic [AW-1:0]    rd_addr_s;
  logic [WIDTH-1:0] rd_data_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});
  assign wr_en_s = bus.push && !full_s;
  assign rd_en_s = bus.pop && !empty_s;

  // In FWFT mode the read port looks ahead to the next head so data_o stays registered.
  assign rd_addr_s = IS_FWFT ? rd_ptr_d : rd_ptr_q;

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (wr_en_s && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_i),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  always_comb begin
    wr_ptr_d = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovf_d    = bus.push && full_s;
    unf_d    = bus.pop && empty_s;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    data_d = data_q;
    if (IS_FWFT) begin
      // Head word being written this cycle is not yet in memory: forward it.
      if (count_d != {CW{1'b0}}) begin
        if (wr_en_s && (rd_ptr_d == wr_ptr_q)) begin
          data_d = bus.data_i;
        end else begin
          data_d = rd_data_s;
        end
      end else begin
        data_d = data_q;
      end
    end else begin
      if (rd_en_s) begin
        data_d = rd_data_s;
      end else begin
        data_d = data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      data_q   <= {WIDTH{1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.data_o       = data_q;
  assign bus.count        = count_q;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives a registered-read and an FWFT FIFO with identical stimulus and checks
// both against a queue-based reference model every cycle.
module tb_param_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic       clk = 1'b0;
  logic       rst, push, pop;
  logic [7:0] din;

  always #5 clk = ~clk;

  param_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  param_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

  assign bus0.push = push;
  assign bus0.pop = pop;
  assign bus0.data_i = din;
  assign bus1.push = push;
  assign bus1.pop = pop;
  assign bus1.data_i = din;

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Reference model: contents as a queue, plus the last word shown by each read mode.
  logic [7:0] mq[$];
  logic [7:0] m_std, m_fwft;
  logic       m_ovf, m_unf;
  bit         chk_en = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic p, input logic o, input logic [7:0] d);
    int sz;
    sz = mq.size();
    if (r) begin
      mq.delete();
      m_std = 8'h00; m_fwft = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_ovf = p && (sz == D);
      m_unf = o && (sz == 0);
      if (o && sz > 0) m_std = mq.pop_front();
      if (p && sz < D) mq.push_back(d);
      if (mq.size() > 0) m_fwft = mq[0];
    end
  endtask

  task automatic apply(input logic r, input logic p, input logic o, input logic [7:0] d);
    rst = r; push = p; pop = o; din = d;
    @(posedge clk);
    model_update(r, p, o, d);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count0", 32'(bus0.count), 32'(mq.size()));
      chk("count1", 32'(bus1.count), 32'(mq.size()));
      chk("full0", 32'(bus0.full), 32'(mq.size() == D));
      chk("empty0", 32'(bus0.empty), 32'(mq.size() == 0));
      chk("afull0", 32'(bus0.almost_full), 32'(mq.size() >= AF));
      chk("aempty0", 32'(bus0.almost_empty), 32'(mq.size() <= AE));
      chk("full1", 32'(bus1.full), 32'(mq.size() == D));
      chk("empty1", 32'(bus1.empty), 32'(mq.size() == 0));
      chk("ovf0", 32'(bus0.overflow), 32'(m_ovf));
      chk("unf0", 32'(bus0.underflow), 32'(m_unf));
      chk("ovf1", 32'(bus1.overflow), 32'(m_ovf));
      chk("unf1", 32'(bus1.underflow), 32'(m_unf));
      chk("data_std", 32'(bus0.data_o), 32'(m_std));
      chk("data_fwft", 32'(bus1.data_o), 32'(m_fwft));
    end
  end

  initial begin
    logic [7:0] seq [4];
    int pp, po;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    apply(1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    chk("lit_rst_count", 32'(bus0.count), 32'd0);
    chk("lit_rst_empty", 32'(bus0.empty), 32'd1);
    chk("lit_rst_aempty", 32'(bus0.almost_empty), 32'd1);
    chk("lit_rst_afull", 32'(bus0.almost_full), 32'd0);
    chk("lit_rst_data", 32'(bus0.data_o), 32'd0);

    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'b0, seq[i]);
    chk("lit_fill_full", 32'(bus0.full), 32'd1);
    chk("lit_fill_count", 32'(bus0.count), 32'd4);
    apply(1'b0, 1'b1, 1'b0, 8'h55);
    chk("lit_ovf", 32'(bus0.overflow), 32'd1);
    chk("lit_ovf_count", 32'(bus0.count), 32'd4);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk("lit_ovf_pulse", 32'(bus0.overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 1'b1, 8'h00);
      chk("lit_pop_data", 32'(bus0.data_o), 32'(seq[i]));
      if (i == 0) chk("lit_afull_at3", 32'(bus0.almost_full), 32'd1);
    end
    chk("lit_drained", 32'(bus0.count), 32'd0);
    apply(1'b0, 1'b0, 1'b1, 8'h00);
    chk("lit_unf", 32'(bus0.underflow), 32'd1);
    chk("lit_unf_data", 32'(bus0.data_o), 32'h44);

    apply(1'b0, 1'b1, 1'b0, 8'hA0);
    apply(1'b0, 1'b1, 1'b0, 8'hA1);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 1'b1, 8'h66 + 8'(i));
      chk("lit_wrap_count", 32'(bus0.count), 32'd2);
      chk("lit_wrap_data", 32'(bus0.data_o),
          (i == 0) ? 32'hA0 : (i == 1) ? 32'hA1 : 32'(8'h66 + 8'(i - 2)));
    end

    apply(1'b0, 1'b1, 1'b0, 8'h01);
    chk("lit_cnt3", 32'(bus0.count), 32'd3);
    apply(1'b1, 1'b1, 1'b0, 8'h77);
    chk("lit_rstp_count", 32'(bus0.count), 32'd0);
    chk("lit_rstp_empty", 32'(bus0.empty), 32'd1);
    chk("lit_rstp_data", 32'(bus0.data_o), 32'd0);
    chk("lit_rstp_ovf", 32'(bus0.overflow), 32'd0);

    apply(1'b0, 1'b1, 1'b0, 8'hA5);
    chk("lit_fwft_show", 32'(bus1.data_o), 32'hA5);
    apply(1'b0, 1'b0, 1'b1, 8'h00);
    chk("lit_fwft_empty", 32'(bus1.empty), 32'd1);
    chk("lit_fwft_hold", 32'(bus1.data_o), 32'hA5);

    pp = 50; po = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        pp = $urandom_range(20, 85);
        po = $urandom_range(20, 85);
      end
      apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < pp),
            ($urandom_range(0, 99) < po), 8'($urandom));
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, >=2.
REQ-003 Parameter AF_THRESH, default DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
REQ-004 Parameter AE_THRESH, default 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
REQ-005 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  clock, all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 push  input  1  write request.
REQ-010 data_i  input  WIDTH  write data, sampled with an accepted push.
REQ-011 pop  input  1  read request.
REQ-012 data_o  output  WIDTH  read data.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 almost_full  output  1  count >= AF_THRESH.
REQ-016 almost_empty  output  1  count <= AE_THRESH.
REQ-017 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-018 overflow  output  1  one-cycle pulse: push rejected.
REQ-019 underflow  output  1  one-cycle pulse: pop rejected.

Function
REQ-020 Push accepted iff push && !full; data_i written at wr_ptr, wr_ptr increments.
REQ-021 Pop accepted iff pop && !empty; rd_ptr increments.
REQ-022 Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 without extra logic.
REQ-023 count: +1 on push-only accept, -1 on pop-only accept, unchanged when both or neither accepted.
REQ-024 Simultaneous push and pop when 0<count<DEPTH: both accepted, count unchanged.
REQ-025 Simultaneous push and pop when empty: push accepted, pop rejected (underflow=1), count -> 1.
REQ-026 Simultaneous push and pop when full: pop accepted, push rejected (overflow=1), count -> DEPTH-1.
REQ-027 overflow/underflow registered, high exactly the cycle after the rejected request, else 0.
REQ-028 full, empty, almost_full, almost_empty decoded combinationally from the count register; no extra latency.
REQ-029 FWFT=0: data_o registered; updates one cycle after an accepted pop with the popped word; otherwise holds.
REQ-030 FWFT=1: data_o shows mem[rd_ptr] whenever !empty, same cycle the word is written-visible (cycle after its push); pop advances to next word; value undefined-but-stable when empty is not required, data_o SHALL hold last value.
REQ-031 A rejected push or pop SHALL NOT modify memory, pointers, count or data_o.

Reset
REQ-032 rst high at a clock edge: wr_ptr=0, rd_ptr=0, count=0, data_o=0, overflow=0, underflow=0.
REQ-033 After reset: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-034 rst has priority over push/pop in the same cycle; reset mid-operation discards all contents.
REQ-035 Memory array SHALL NOT be reset.

Structure
REQ-036 Package fifo_pkg holds default constants (FIFO_DEF_WIDTH, FIFO_DEF_DEPTH) and the read-mode enum (FIFO_MODE_STD, FIFO_MODE_FWFT).
REQ-037 Storage SHALL be sub-module fifo_mem: DEPTH x WIDTH, one sync write port, one read port, no reset.
REQ-038 Elaboration SHALL fail on non-power-of-two DEPTH or out-of-range thresholds.

Verification (WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-039 Push 0x11,0x22,0x33,0x44 then pop 4 (FWFT=0) -> data_o 0x11..0x44 each one cycle after pop; count 4 -> 0; full at count 4, almost_full at 3.
REQ-040 Fill to 4, push 0x55 -> overflow=1 one cycle, count stays 4, subsequent reads return 0x11..0x44.
REQ-041 Pop when empty -> underflow=1 one cycle, data_o unchanged, count 0.
REQ-042 count=2, push 0x66 with pop for 8 cycles -> count stays 2, pointers wrap, FIFO order preserved.
REQ-043 count=3, assert rst with push -> next cycle count=0, empty=1, data_o=0, no overflow.
REQ-044 FWFT=1: push 0xA5 -> data_o=0xA5 next cycle with no pop; pop -> empty=1, data_o holds 0xA5.
